mem_access_unit: RTL and testbench

- Load/store front end between the core's memory request interface and the byte-lane data RAM (four byte-wide banks, synchronous read, word-indexed).
- Converts byte-addressed byte/halfword/word requests into RAM accesses with byte enables and lane-shifted write data.
- Extracts, recombines and sign/zero-extends read data.
- Misaligned halfword/word accesses that straddle a word boundary are split into two RAM accesses by an internal FSM.

---
 rtl/mem_pkg.sv | 17 +
 rtl/lane_align.sv | 26 ++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: size encodings, lane masks and FSM states shared by the load/store front end.
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef enum logic [2:0] {IDLE, P1, P2, FIN, RSP} state_t;

    // Size code 3 is treated as a word.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        return size == SZ_BYTE ? MASK_BYTE : size == SZ_HALF ? MASK_HALF : MASK_WORD;
    endfunction
endpackage

// File: rtl/lane_align.sv
// lane_align: byte enables, lane-shifted store data and split detection for one access phase.
module lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        phase,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic        split
);
    logic [3:0] mask;
    logic [2:0] back;
    logic [5:0] bits;

    // Phase 1 shifts the access up into the first word; phase 2 carries the bytes that spilled past lane 3.
    always_comb begin
        mask     = size_mask(size);
        back     = 3'd4 - {1'b0, off};
        bits     = {off, 3'b000};
        split    = (size == SZ_HALF && off == 2'd3) || (size >= SZ_WORD && off != 2'd0);
        be       = phase ? mask >> back : mask << off;
        wdata_sh = phase ? wdata >> (6'd32 - bits) : wdata << bits;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store front end for a four-lane word RAM,
// splitting boundary-straddling accesses into two RAM phases.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAM_IDX_W = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam int WI_W = ADDR_W - 2;

    // The RAM decodes only the low RAM_IDX_W index bits; the full word index is driven regardless.
    if (RAM_IDX_W > WI_W) begin : g_idx_wider_than_index
    end

    state_t          state_q, state_d;
    logic            we_q, we_d, sgn_q, sgn_d;
    logic [1:0]      size_q, size_d, off_q, off_d;
    logic [WI_W-1:0] widx_q, widx_d, widx_inc;
    logic [31:0]     wdata_q, wdata_d, cap_q, cap_d;
    logic            rsp_valid_q, rsp_valid_d, ram_we_q, ram_we_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d, ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d;
    logic [3:0]      ram_be_q, ram_be_d;
    logic            idle, la_split;
    logic [1:0]      la_size, la_off;
    logic [31:0]     la_wdata, la_wdata_sh, lo, raw, ld_data;
    logic [3:0]      la_be;

    // In IDLE the aligner sees the live request so phase 1 can be registered on the accept edge.
    assign idle     = state_q == IDLE;
    assign la_size  = idle ? req_size : size_q;
    assign la_off   = idle ? req_addr[1:0] : off_q;
    assign la_wdata = idle ? req_wdata : wdata_q;
    assign widx_inc = widx_q + WI_W'(1);

    lane_align u_align (
        .size     (la_size),
        .off      (la_off),
        .phase    (state_q == P1),
        .wdata    (la_wdata),
        .be       (la_be),
        .wdata_sh (la_wdata_sh),
        .split    (la_split)
    );

    // A split load's first word waits in cap_q while the second arrives on ram_rdata.
    assign lo      = la_split ? cap_q : ram_rdata;
    assign raw     = 32'({ram_rdata, lo} >> {off_q, 3'b000});
    assign ld_data = size_q == SZ_BYTE ? {{24{sgn_q & raw[7]}}, raw[7:0]} :
                     size_q == SZ_HALF ? {{16{sgn_q & raw[15]}}, raw[15:0]} : raw;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        off_d       = off_q;
        widx_d      = widx_q;
        wdata_d     = wdata_q;
        cap_d       = cap_q;
        rsp_rdata_d = rsp_rdata_q;
        ram_we_d    = 1'b0;
        ram_be_d    = 4'b0000;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d     = P1;
                we_d        = req_we;
                size_d      = req_size;
                sgn_d       = req_signed;
                off_d       = req_addr[1:0];
                widx_d      = req_addr[ADDR_W-1:2];
                wdata_d     = req_wdata;
                ram_we_d    = req_we;
                ram_be_d    = la_be;
                ram_addr_d  = 32'(req_addr[ADDR_W-1:2]);
                ram_wdata_d = la_wdata_sh;
            end
            P1: if (la_split) begin
                state_d     = P2;
                ram_we_d    = we_q;
                ram_be_d    = la_be;
                ram_addr_d  = 32'(widx_inc);
                ram_wdata_d = la_wdata_sh;
            end else begin
                state_d = we_q ? RSP : FIN;
            end
            P2: begin
                state_d = we_q ? RSP : FIN;
                cap_d   = ram_rdata;
            end
            FIN: begin
                state_d     = RSP;
                rsp_rdata_d = ld_data;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == RSP && we_q) rsp_rdata_d = '0;
        rsp_valid_d = state_d == RSP;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            off_q       <= '0;
            widx_q      <= '0;
            wdata_q     <= '0;
            cap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            off_q       <= off_d;
            widx_q      <= widx_d;
            wdata_q     <= wdata_d;
            cap_q       <= cap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_we_q    <= ram_we_d;
            ram_be_q    <= ram_be_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign req_ready = idle;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_we    = ram_we_q;
    assign ram_be    = ram_be_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives directed and random loads/stores into mem_access_unit backed by a
// word RAM, checking responses against a byte-addressed reference memory.
module tb_mem_access_unit;
    logic        clk = 1'b0, reset_n = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0, ram_rdata;
    logic        req_ready, rsp_valid, ram_we;
    logic [31:0] rsp_rdata, ram_addr, ram_wdata;
    logic [3:0]  ram_be;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    bit   [31:0] ram[2048];
    bit   [7:0]  ref_mem[8192];
    int          cyc = 0, n_vec = 0, n_err = 0, prev_due = 0;
    bit          have_prev = 1'b0;
    logic [31:0] last_rsp = '0;

    mem_access_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .ram_we     (ram_we),
        .ram_be     (ram_be),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-lane RAM decoding the low 11 word-index bits, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) ram[ram_addr[10:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= ram[ram_addr[10:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int n = nbytes(sz);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[13'(a + 32'(i))];
        if (sg && n < 4 && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[13'(a + 32'(i))] = d[8*i +: 8];
    endfunction

    // Response checker: every cycle out of reset, against the queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            last_rsp = '0;
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.data);
                chk("rsp_cycle", 32'(cyc), 32'(e.due));
                last_rsp = e.data;
            end
        end else begin
            chk("rsp_hold", rsp_rdata, last_rsp);
            if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
                chk("rsp_missing", 32'(cyc), 32'(exp_q[0].due));
                void'(exp_q.pop_front());
            end
        end
    end

    // Present one request; returns #1 after the accept edge (first RAM phase visible).
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input int gap, input bit abort, input bit pin,
                         input logic [31:0] lit);
        int w, n, lat, c0;
        logic [31:0] v;
        exp_t e;
        repeat (gap) @(negedge clk);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!req_ready && w < 20);
        if (!req_ready) begin
            chk("ready_timeout", 32'(req_ready), 32'd1);
            $fatal(1, "request never accepted");
        end
        if (gap == 0 && have_prev) chk("ready_cycle", 32'(cyc), 32'(prev_due + 1));
        c0 = cyc;
        req_we = we;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom);
        req_size = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        if (abort) return;
        n = nbytes(sz);
        lat = (we ? 2 : 3) + ((32'(a[1:0]) + 32'(n) > 32'd4) ? 1 : 0);
        if (we) begin
            model_store(a, sz, wd);
            v = '0;
        end else begin
            v = model_load(a, sz, sg);
        end
        if (pin) chk("model_pin", v, lit);
        e.data = v;
        e.due = c0 + lat;
        exp_q.push_back(e);
        prev_due = e.due;
        have_prev = 1'b1;
    endtask

    task automatic probe(input string tag, input logic we, input logic [3:0] be, input logic [31:0] addr);
        chk({tag, "_we"}, 32'(ram_we), 32'(we));
        chk({tag, "_be"}, 32'(ram_be), 32'(be));
        chk({tag, "_addr"}, ram_addr, addr);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_ram_be"}, 32'(ram_be), 32'd0);
        chk({tag, "_ram_addr"}, ram_addr, 32'd0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int w;
        logic [31:0] a;
        #3 reset_n = 1'b0;
        #1 rst_chk("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        issue(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0);
        probe("st_word", 1, 4'b1111, 32'h40);
        chk("st_word_wdata", ram_wdata, 32'hDEADBEEF);
        issue(0, 2'd2, 0, 32'h100, 0, 0, 0, 1, 32'hDEADBEEF);
        probe("ld_word", 0, 4'b1111, 32'h40);

        issue(1, 2'd2, 0, 32'h100, 32'h80FF7F01, 0, 0, 0, 0);
        issue(0, 2'd0, 1, 32'h102, 0, 0, 0, 1, 32'hFFFFFFFF);
        issue(0, 2'd0, 0, 32'h102, 0, 0, 0, 1, 32'h000000FF);
        issue(0, 2'd0, 1, 32'h103, 0, 0, 0, 1, 32'hFFFFFF80);
        issue(0, 2'd1, 1, 32'h101, 0, 0, 0, 1, 32'hFFFFFF7F);

        issue(1, 2'd1, 0, 32'h103, 32'h0000A1B2, 0, 0, 0, 0);
        probe("sp_half_p1", 1, 4'b1000, 32'h40);
        chk("sp_half_p1_byte", 32'(ram_wdata[31:24]), 32'hB2);
        @(posedge clk);
        #1 probe("sp_half_p2", 1, 4'b0001, 32'h41);
        chk("sp_half_p2_byte", 32'(ram_wdata[7:0]), 32'hA1);
        issue(0, 2'd1, 1, 32'h103, 0, 0, 0, 1, 32'hFFFFA1B2);

        issue(1, 2'd2, 0, 32'h101, 32'h11223344, 0, 0, 0, 0);
        probe("sp_word_p1", 1, 4'b1110, 32'h40);
        @(posedge clk);
        #1 probe("sp_word_p2", 1, 4'b0001, 32'h41);
        issue(0, 2'd2, 0, 32'h101, 0, 0, 0, 1, 32'h11223344);
        issue(0, 2'd0, 0, 32'h100, 0, 0, 0, 1, 32'h00000001);
        issue(0, 2'd0, 0, 32'h105, 0, 0, 0, 1, 32'h00000000);

        issue(1, 2'd2, 0, 32'hFFFFFFFE, 32'h55667788, 0, 0, 0, 0);
        probe("wrap_p1", 1, 4'b1100, 32'h3FFFFFFF);
        @(posedge clk);
        #1 probe("wrap_p2", 1, 4'b0011, 32'h0);
        issue(0, 2'd2, 0, 32'hFFFFFFFE, 0, 0, 0, 1, 32'h55667788);

        // Reset while the second half of a split store is on the RAM port.
        issue(1, 2'd2, 0, 32'h101, 32'hCAFEBABE, 0, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1 rst_chk("midreset");
        exp_q.delete();
        have_prev = 1'b0;
        model_store(32'h101, 2'd1, 32'h0000BABE);
        model_store(32'h103, 2'd0, 32'h000000FE);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("post_reset_ready", 32'(req_ready), 32'd1);
        issue(0, 2'd2, 0, 32'h100, 0, 0, 0, 1, 32'hFEBABE01);
        issue(0, 2'd0, 0, 32'h104, 0, 0, 0, 1, 32'h00000011);

        for (int t = 0; t < 300; t++) begin
            a = ($urandom_range(0, 1) == 0 ? 32'h100 : 32'hFFFFFFC0) + 32'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a,
                  $urandom, $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0, 0, 0, 0);
        end

        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
